// File: rtl/control_pipeline_pkg.sv
// Shared definitions for the control pipeline.
//   - Control bundle layout (bit indices into the 11-bit decoder word).
//   - Bundle / register-address widths and the bubble encoding.
//   - Packed records carried by the ID/EX, EX/MEM and MEM/WB registers.
package control_pipeline_pkg;

    localparam int CTRL_W = 11;
    localparam int RA_W   = 5;

    localparam int IDX_REGDST    = 10;
    localparam int IDX_ALUSRC    = 9;
    localparam int IDX_MEMTOREG  = 8;
    localparam int IDX_REGWRITE  = 7;
    localparam int IDX_MEMREAD   = 6;
    localparam int IDX_MEMWRITE  = 5;
    localparam int IDX_BRANCHNE  = 4;
    localparam int IDX_BRANCHEQ  = 3;
    localparam int IDX_ALUOP_MSB = 2;
    localparam int IDX_ALUOP_LSB = 0;

    // A bubble is an all-zero control word: no register write, no memory
    // access, no branch.
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 11'b0;

    // rs is only needed by the hazard check, which looks at the ID copy,
    // so EX carries just rt and rd.
    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [RA_W-1:0]   rt;
        logic [RA_W-1:0]   rd;
    } id_ex_t;

    typedef struct packed {
        logic            valid;
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
        logic            memto_reg;
        logic [RA_W-1:0] write_reg;
    } ex_mem_t;

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            memto_reg;
        logic [RA_W-1:0] write_reg;
    } mem_wb_t;

endpackage

// File: rtl/control_pipeline_stage_reg.sv
// pipe_stage_reg: generic pipeline register.
//   clk_i    rising-edge clock
//   rst_ni   asynchronous active-low reset, clears to the bubble (all zero)
//   en_i     load enable
//   clear_i  synchronous clear-to-bubble, has priority over en_i
//   d_i/q_o  WIDTH-bit data in / registered data out
module pipe_stage_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else if (clear_i) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/control_pipeline.sv
// control_pipeline: stages the decoder control word through ID/EX, EX/MEM
// and MEM/WB, computes the EX destination register, inserts a bubble on a
// load-use hazard and squashes the wrong-path ID instruction on a taken
// BEQ/BNE resolved in EX.
//   clk, reset (async, active-low)
//   id_valid/id_ctrl/id_rs/id_rt/id_rd  instruction currently in ID
//   alu_zero                            ALU zero flag of the EX instruction
//   stall   hold PC and IF/ID for one cycle (load-use)
//   flush   taken branch, clear IF/ID
//   ex_*/mem_*/wb_*                     stage-local control, valid-gated
module control_pipeline
    import control_pipeline_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [RA_W-1:0]   id_rs,
    input  logic [RA_W-1:0]   id_rt,
    input  logic [RA_W-1:0]   id_rd,
    input  logic              alu_zero,
    output logic              stall,
    output logic              flush,
    output logic              ex_ALUSrc,
    output logic [2:0]        ex_ALUOp,
    output logic [RA_W-1:0]   ex_write_reg,
    output logic              mem_MemRead,
    output logic              mem_MemWrite,
    output logic [RA_W-1:0]   mem_write_reg,
    output logic              wb_RegWrite,
    output logic              wb_MemtoReg,
    output logic [RA_W-1:0]   wb_write_reg
);

    id_ex_t  id_ex_d,  id_ex_q;
    ex_mem_t ex_mem_d, ex_mem_q;
    mem_wb_t mem_wb_d, mem_wb_q;

    logic            hazard;
    logic            taken;
    logic            id_uses_rt;
    logic [RA_W-1:0] ex_dest;

    // rt is a true source unless the instruction takes an immediate;
    // stores read rt as the data operand even though ALUSrc is set.
    assign id_uses_rt = ~id_ctrl[IDX_ALUSRC] | id_ctrl[IDX_MEMWRITE];

    assign hazard = id_valid & id_ex_q.valid & id_ex_q.ctrl[IDX_MEMREAD]
                  & (id_ex_q.rt != '0)
                  & ((id_ex_q.rt == id_rs) | ((id_ex_q.rt == id_rt) & id_uses_rt));

    assign taken = id_ex_q.valid
                 & ((id_ex_q.ctrl[IDX_BRANCHEQ] & alu_zero)
                  | (id_ex_q.ctrl[IDX_BRANCHNE] & ~alu_zero));

    // A wrong-path ID instruction must not stall; the flush discards it.
    assign stall = hazard & ~taken;
    assign flush = taken;

    assign ex_dest = id_ex_q.ctrl[IDX_REGDST] ? id_ex_q.rd : id_ex_q.rt;

    always_comb begin
        id_ex_d       = '0;
        id_ex_d.valid = id_valid;
        id_ex_d.ctrl  = id_ctrl;
        id_ex_d.rt    = id_rt;
        id_ex_d.rd    = id_rd;

        ex_mem_d           = '0;
        ex_mem_d.valid     = id_ex_q.valid;
        ex_mem_d.mem_read  = id_ex_q.ctrl[IDX_MEMREAD];
        ex_mem_d.mem_write = id_ex_q.ctrl[IDX_MEMWRITE];
        ex_mem_d.reg_write = id_ex_q.ctrl[IDX_REGWRITE];
        ex_mem_d.memto_reg = id_ex_q.ctrl[IDX_MEMTOREG];
        ex_mem_d.write_reg = ex_dest;

        mem_wb_d           = '0;
        mem_wb_d.valid     = ex_mem_q.valid;
        mem_wb_d.reg_write = ex_mem_q.reg_write;
        mem_wb_d.memto_reg = ex_mem_q.memto_reg;
        mem_wb_d.write_reg = ex_mem_q.write_reg;
    end

    // ID/EX takes a bubble (not a hold) on hazard or flush: ID itself is
    // held upstream by stall, so the instruction re-presents next cycle.
    pipe_stage_reg #(.WIDTH($bits(id_ex_t))) u_id_ex (
        .clk_i   (clk),
        .rst_ni  (reset),
        .en_i    (1'b1),
        .clear_i (hazard | taken),
        .d_i     (id_ex_d),
        .q_o     (id_ex_q)
    );

    pipe_stage_reg #(.WIDTH($bits(ex_mem_t))) u_ex_mem (
        .clk_i   (clk),
        .rst_ni  (reset),
        .en_i    (1'b1),
        .clear_i (1'b0),
        .d_i     (ex_mem_d),
        .q_o     (ex_mem_q)
    );

    pipe_stage_reg #(.WIDTH($bits(mem_wb_t))) u_mem_wb (
        .clk_i   (clk),
        .rst_ni  (reset),
        .en_i    (1'b1),
        .clear_i (1'b0),
        .d_i     (mem_wb_d),
        .q_o     (mem_wb_q)
    );

    assign ex_ALUSrc     = id_ex_q.valid & id_ex_q.ctrl[IDX_ALUSRC];
    assign ex_ALUOp      = {3{id_ex_q.valid}} & id_ex_q.ctrl[IDX_ALUOP_MSB:IDX_ALUOP_LSB];
    assign ex_write_reg  = ex_dest;

    assign mem_MemRead   = ex_mem_q.valid & ex_mem_q.mem_read;
    assign mem_MemWrite  = ex_mem_q.valid & ex_mem_q.mem_write;
    assign mem_write_reg = ex_mem_q.write_reg;

    assign wb_RegWrite   = mem_wb_q.valid & mem_wb_q.reg_write;
    assign wb_MemtoReg   = mem_wb_q.valid & mem_wb_q.memto_reg;
    assign wb_write_reg  = mem_wb_q.write_reg;

endmodule

// File: tb/tb_control_pipeline.sv
`timescale 1ns/1ps
module tb_control_pipeline;

    // Control words, layout RegDst ALUSrc MemtoReg RegWrite MemRead MemWrite BNE BEQ ALUOp[2:0]
    localparam logic [10:0] C_NOP   = 11'h000;
    localparam logic [10:0] C_ADDI  = 11'h284;
    localparam logic [10:0] C_ORI   = 11'h285;
    localparam logic [10:0] C_LW    = 11'h3C0;
    localparam logic [10:0] C_SW    = 11'h220;
    localparam logic [10:0] C_ADD   = 11'h482;
    localparam logic [10:0] C_BEQ   = 11'h009;
    localparam logic [10:0] C_BNE   = 11'h011;
    localparam logic [10:0] C_LWBNE = 11'h3D0;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [10:0] id_ctrl;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        alu_zero;
    logic        stall, flush, ex_ALUSrc;
    logic [2:0]  ex_ALUOp;
    logic [4:0]  ex_write_reg;
    logic        mem_MemRead, mem_MemWrite;
    logic [4:0]  mem_write_reg;
    logic        wb_RegWrite, wb_MemtoReg;
    logic [4:0]  wb_write_reg;

    always #5 clk = ~clk;

    control_pipeline dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_ctrl       (id_ctrl),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rd         (id_rd),
        .alu_zero      (alu_zero),
        .stall         (stall),
        .flush         (flush),
        .ex_ALUSrc     (ex_ALUSrc),
        .ex_ALUOp      (ex_ALUOp),
        .ex_write_reg  (ex_write_reg),
        .mem_MemRead   (mem_MemRead),
        .mem_MemWrite  (mem_MemWrite),
        .mem_write_reg (mem_write_reg),
        .wb_RegWrite   (wb_RegWrite),
        .wb_MemtoReg   (wb_MemtoReg),
        .wb_write_reg  (wb_write_reg)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each in-flight instruction is a record; the pipe is three slots
    // (EX, MEM, WB) shifted once per clock.
    typedef struct {
        bit        v;
        bit [10:0] c;
        bit [4:0]  rt;
        bit [4:0]  dest;
    } instr_t;

    instr_t pipe_m[3];
    bit     m_hazard, m_taken;

    function automatic instr_t empty_slot();
        instr_t e;
        e.v = 0; e.c = '0; e.rt = '0; e.dest = '0;
        return e;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) pipe_m[k] = empty_slot();
    endtask

    // Compare every DUT output against what the pipe contents imply.
    task automatic model_compare();
        instr_t ex, mem, wb;
        bit reads_rt;
        ex = pipe_m[0]; mem = pipe_m[1]; wb = pipe_m[2];
        m_taken = ex.v && ((ex.c[3] && alu_zero) || (ex.c[4] && !alu_zero));
        reads_rt = !id_ctrl[9] || id_ctrl[5];
        m_hazard = id_valid && ex.v && ex.c[6] && (ex.rt != 0) &&
                   ((ex.rt == id_rs) || (reads_rt && ex.rt == id_rt));
        check("m_stall",     stall,         m_hazard && !m_taken);
        check("m_flush",     flush,         m_taken);
        check("m_exALUSrc",  ex_ALUSrc,     ex.v ? ex.c[9] : 1'b0);
        check("m_exALUOp",   ex_ALUOp,      ex.v ? ex.c[2:0] : 3'd0);
        check("m_exwr",      ex_write_reg,  ex.dest);
        check("m_memRead",   mem_MemRead,   mem.v ? mem.c[6] : 1'b0);
        check("m_memWrite",  mem_MemWrite,  mem.v ? mem.c[5] : 1'b0);
        check("m_memwr",     mem_write_reg, mem.dest);
        check("m_wbRegWr",   wb_RegWrite,   wb.v ? wb.c[7] : 1'b0);
        check("m_wbMemtoReg",wb_MemtoReg,   wb.v ? wb.c[8] : 1'b0);
        check("m_wbwr",      wb_write_reg,  wb.dest);
    endtask

    task automatic model_clock();
        instr_t n;
        pipe_m[2] = pipe_m[1];
        pipe_m[1] = pipe_m[0];
        if (m_hazard || m_taken) begin
            n = empty_slot();
        end else begin
            n.v = id_valid; n.c = id_ctrl; n.rt = id_rt;
            n.dest = id_ctrl[10] ? id_rd : id_rt;
        end
        pipe_m[0] = n;
    endtask

    // Called just after a falling edge: drive ID, settle, compare.
    task automatic apply(input logic v, input logic [10:0] c, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic z);
        id_valid = v; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd; alu_zero = z;
        #1;
        model_compare();
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_flush"}, flush, 0);
        check({tag, "_ex"},  {ex_ALUSrc, ex_ALUOp, ex_write_reg}, 0);
        check({tag, "_mem"}, {mem_MemRead, mem_MemWrite, mem_write_reg}, 0);
        check({tag, "_wb"},  {wb_RegWrite, wb_MemtoReg, wb_write_reg}, 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        v;
        logic [10:0] c;
        logic [4:0]  rs, rt, rd;
        logic        z;
        logic        e_stall, e_flush;
        logic [2:0]  e_aluop;
        logic [4:0]  e_exwr;
        logic        e_wbrw;
        logic [4:0]  e_wbwr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [10:0] c, logic [4:0] rs, logic [4:0] rt,
                                logic [4:0] rd, logic z, logic es, logic ef, logic [2:0] ea,
                                logic [4:0] ex, logic ew, logic [4:0] eww);
        vec_t r;
        r.v = v; r.c = c; r.rs = rs; r.rt = rt; r.rd = rd; r.z = z;
        r.e_stall = es; r.e_flush = ef; r.e_aluop = ea; r.e_exwr = ex;
        r.e_wbrw = ew; r.e_wbwr = eww;
        return r;
    endfunction

    task automatic fill_table();
        // ADDI then ORI
        tbl.push_back(mk(1, C_ADDI, 1, 2, 0, 0,  0, 0, 3'b000, 0, 0, 0));
        tbl.push_back(mk(1, C_ORI,  1, 3, 0, 0,  0, 0, 3'b100, 2, 0, 0));
        tbl.push_back(mk(0, C_NOP,  0, 0, 0, 0,  0, 0, 3'b101, 3, 0, 0));
        tbl.push_back(mk(0, C_NOP,  0, 0, 0, 0,  0, 0, 3'b000, 0, 1, 2));
        tbl.push_back(mk(0, C_NOP,  0, 0, 0, 0,  0, 0, 3'b000, 0, 1, 3));
        tbl.push_back(mk(0, C_NOP,  0, 0, 0, 0,  0, 0, 3'b000, 0, 0, 0));
        // LW rt=8 then dependent ADD rs=8 (re-presented after the stall)
        tbl.push_back(mk(1, C_LW,   1, 8, 0, 0,  0, 0, 3'b000, 0, 0, 0));
        tbl.push_back(mk(1, C_ADD,  8, 9, 10, 0, 1, 0, 3'b000, 8, 0, 0));
        tbl.push_back(mk(1, C_ADD,  8, 9, 10, 0, 0, 0, 3'b000, 0, 0, 0));
        tbl.push_back(mk(0, C_NOP,  0, 0, 0, 0,  0, 0, 3'b010, 10, 1, 8));
        tbl.push_back(mk(0, C_NOP,  0, 0, 0, 0,  0, 0, 3'b000, 0, 0, 0));
        tbl.push_back(mk(0, C_NOP,  0, 0, 0, 0,  0, 0, 3'b000, 0, 1, 10));
        tbl.push_back(mk(0, C_NOP,  0, 0, 0, 0,  0, 0, 3'b000, 0, 0, 0));
        // LW rt=0 then ADD rs=0: no stall
        tbl.push_back(mk(1, C_LW,   1, 0, 0, 0,  0, 0, 3'b000, 0, 0, 0));
        tbl.push_back(mk(1, C_ADD,  0, 9, 10, 0, 0, 0, 3'b000, 0, 0, 0));
        tbl.push_back(mk(0, C_NOP,  0, 0, 0, 0,  0, 0, 3'b010, 10, 0, 0));
        tbl.push_back(mk(0, C_NOP,  0, 0, 0, 0,  0, 0, 3'b000, 0, 1, 0));
        tbl.push_back(mk(0, C_NOP,  0, 0, 0, 0,  0, 0, 3'b000, 0, 1, 10));
        tbl.push_back(mk(0, C_NOP,  0, 0, 0, 0,  0, 0, 3'b000, 0, 0, 0));
        // BEQ taken: following ADDI squashed
        tbl.push_back(mk(1, C_BEQ,  1, 2, 0, 0,  0, 0, 3'b000, 0, 0, 0));
        tbl.push_back(mk(1, C_ADDI, 1, 5, 0, 1,  0, 1, 3'b001, 2, 0, 0));
        tbl.push_back(mk(0, C_NOP,  0, 0, 0, 0,  0, 0, 3'b000, 0, 0, 0));
        tbl.push_back(mk(0, C_NOP,  0, 0, 0, 0,  0, 0, 3'b000, 0, 0, 2));
        tbl.push_back(mk(0, C_NOP,  0, 0, 0, 0,  0, 0, 3'b000, 0, 0, 0));
        // BEQ not taken: ADDI commits
        tbl.push_back(mk(1, C_BEQ,  1, 2, 0, 0,  0, 0, 3'b000, 0, 0, 0));
        tbl.push_back(mk(1, C_ADDI, 1, 5, 0, 0,  0, 0, 3'b001, 2, 0, 0));
        tbl.push_back(mk(0, C_NOP,  0, 0, 0, 0,  0, 0, 3'b100, 5, 0, 0));
        tbl.push_back(mk(0, C_NOP,  0, 0, 0, 0,  0, 0, 3'b000, 0, 0, 2));
        tbl.push_back(mk(0, C_NOP,  0, 0, 0, 0,  0, 0, 3'b000, 0, 1, 5));
        tbl.push_back(mk(0, C_NOP,  0, 0, 0, 0,  0, 0, 3'b000, 0, 0, 0));
        // Load that is also a taken BNE, dependent ID: flush wins
        tbl.push_back(mk(1, C_LWBNE,1, 8, 0, 0,  0, 0, 3'b000, 0, 0, 0));
        tbl.push_back(mk(1, C_ADD,  8, 9, 10, 0, 0, 1, 3'b000, 8, 0, 0));
        tbl.push_back(mk(0, C_NOP,  0, 0, 0, 0,  0, 0, 3'b000, 0, 0, 0));
        tbl.push_back(mk(0, C_NOP,  0, 0, 0, 0,  0, 0, 3'b000, 0, 1, 8));
        tbl.push_back(mk(0, C_NOP,  0, 0, 0, 0,  0, 0, 3'b000, 0, 0, 0));
    endtask

    function automatic logic [10:0] pick_ctrl(int unsigned k);
        logic [10:0] pool[8];
        pool[0] = C_NOP; pool[1] = C_ADDI; pool[2] = C_ORI; pool[3] = C_LW;
        pool[4] = C_SW;  pool[5] = C_ADD;  pool[6] = C_BEQ; pool[7] = C_BNE;
        return pool[k];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        hv;
        logic [10:0] hc;
        logic [4:0]  hrs, hrt, hrd;
        bit          held;

        // Reset held low with a load/dependent pattern on the inputs.
        reset = 1'b0;
        id_valid = 1'b1; id_ctrl = C_LW; id_rs = 5'd4; id_rt = 5'd4; id_rd = 5'd0;
        alu_zero = 1'b1;
        model_reset();
        @(negedge clk);
        check_all_zero("rst_low0");
        @(negedge clk);
        check_all_zero("rst_low1");
        reset = 1'b1;
        id_valid = 1'b0; id_ctrl = C_NOP; id_rs = '0; id_rt = '0; id_rd = '0; alu_zero = 1'b0;
        #1;
        check_all_zero("rst_rel");

        // Directed table.
        fill_table();
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].v, tbl[i].c, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].z);
            check($sformatf("t%0d_stall", i), stall,        tbl[i].e_stall);
            check($sformatf("t%0d_flush", i), flush,        tbl[i].e_flush);
            check($sformatf("t%0d_aluop", i), ex_ALUOp,     tbl[i].e_aluop);
            check($sformatf("t%0d_exwr", i),  ex_write_reg, tbl[i].e_exwr);
            check($sformatf("t%0d_wbrw", i),  wb_RegWrite,  tbl[i].e_wbrw);
            check($sformatf("t%0d_wbwr", i),  wb_write_reg, tbl[i].e_wbwr);
            tick();
        end

        // Mid-stream reset with three instructions in flight.
        apply(1, C_ADDI, 1, 1, 0, 0); tick();
        apply(1, C_ADDI, 1, 2, 0, 0); tick();
        apply(1, C_LW,   1, 3, 0, 0); tick();
        apply(1, C_ADD,  3, 4, 6, 0);
        check("inflight_memwr", mem_write_reg, 2);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all_zero("rst_async");
        @(posedge clk);
        #1;
        check_all_zero("rst_edge");
        @(negedge clk);
        reset = 1'b1;
        apply(1, C_ORI, 2, 7, 0, 0);
        check_all_zero("rst_refill0");
        tick();
        apply(0, C_NOP, 0, 0, 0, 0);
        check("refill_aluop", ex_ALUOp, 3'b101);
        check("refill_exwr",  ex_write_reg, 7);
        check("refill_mem",   {mem_MemRead, mem_MemWrite, mem_write_reg}, 0);
        check("refill_wb",    {wb_RegWrite, wb_MemtoReg, wb_write_reg}, 0);
        tick();

        // Randomized program; stalled instructions re-present, flushed ones are dropped.
        held = 0;
        hv = 0; hc = C_NOP; hrs = '0; hrt = '0; hrd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!held) begin
                hv  = ($urandom_range(0, 9) != 0);
                hc  = pick_ctrl($urandom_range(0, 7));
                hrs = 5'($urandom_range(0, 3));
                hrt = 5'($urandom_range(0, 3));
                hrd = 5'($urandom_range(0, 3));
            end
            apply(hv, hc, hrs, hrt, hrd, 1'($urandom_range(0, 1)));
            held = m_hazard && !m_taken;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_pipeline.md
Name: control_pipeline

Overview:
- Consumer end of the decoder's control word: takes the 11-bit control bundle produced in ID and stages it through the ID/EX, EX/MEM and MEM/WB registers of the pipelined MIPS core.
- Computes the destination register number in EX.
- Detects load-use hazards and inserts bubbles.
- Resolves BEQ/BNE in EX and squashes the wrong-path instruction.
- Drives every stage-local control line of the datapath. Forwarding is out of scope and handled by a separate unit.

Parameters:
- CTRL_W, 11, width of control bundle. Layout: [10]RegDst [9]ALUSrc [8]MemtoReg [7]RegWrite [6]MemRead [5]MemWrite [4]BranchNE [3]BranchEQ [2:0]ALUOp.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all stage registers.
- id_valid  in  1  ID holds a real instruction.
- id_ctrl  in  CTRL_W  decoded control bundle for the ID instruction.
- id_rs  in  RA_W  instruction rs field.
- id_rt  in  RA_W  instruction rt field.
- id_rd  in  RA_W  instruction rd field.
- alu_zero  in  1  ALU zero flag of the instruction currently in EX.
- stall  out  1  hold PC and IF/ID (load-use).
- flush  out  1  taken branch; clear IF/ID.
- ex_ALUSrc  out  1  EX-stage control.
- ex_ALUOp  out  3  EX-stage control.
- ex_write_reg  out  RA_W  EX destination register.
- mem_MemRead  out  1  MEM-stage control.
- mem_MemWrite  out  1  MEM-stage control.
- mem_write_reg  out  RA_W  MEM destination register.
- wb_RegWrite  out  1  WB-stage control.
- wb_MemtoReg  out  1  WB-stage control.
- wb_write_reg  out  RA_W  WB destination register.

Behaviour:
- Reset:
  - All stage registers clear to the bubble value: ctrl=0, valid=0, reg fields=0.
  - Every output is 0 while reset is low and on the first edge after release.
  - Reset mid-stream discards all in-flight instructions immediately; no partial state survives.
- Stage registers:
  - ID/EX latches {id_valid, id_ctrl, id_rs, id_rt, id_rd} each edge unless bubbled.
  - EX/MEM and MEM/WB always advance; they are never held.
- Destination register:
  - ex_write_reg = RegDst ? ex_rd : ex_rt.
  - The value is registered forward unchanged into MEM and WB.
- Stage output gating: all stage-control outputs are ANDed with that stage's valid bit.
- Latency: one instruction's control appears in EX, MEM and WB on the 1st, 2nd and 3rd edges after it is in ID.
- Load-use hazard:
  - Condition: ex_valid & ex_MemRead & ex_rt!=0 & (ex_rt==id_rs | (ex_rt==id_rt & (~id_ALUSrc | id_MemWrite))) & id_valid.
  - On hazard, stall=1 combinationally and ID/EX loads a bubble on the next edge.
  - ID content is held externally, so the instruction re-presents and proceeds one cycle later.
- Branch:
  - taken = ex_valid & ((ex_BranchEQ & alu_zero) | (ex_BranchNE & ~alu_zero)).
  - flush = taken. ID/EX loads a bubble on the next edge, discarding the wrong-path ID instruction.
  - The branch itself continues to MEM and WB; with RegWrite=0 and MemWrite=0 it has no effect.
- Simultaneous events: when taken and hazard are both true, flush wins and stall is forced to 0. The ID instruction is wrong-path, so it must not stall.
- Register $0: an rt of 0 never causes a stall.
- Structure: no FSM state beyond the valid bits; stall lasts exactly one cycle per hazard, because the load moves to MEM.

Decomposition:
- Shared package holds:
  - control bit-index constants (IDX_REGDST=10 … IDX_ALUOP_LSB=0);
  - CTRL_W and RA_W;
  - CTRL_BUBBLE = 11'b0.
- One sub-module: pipe_stage_reg, a generic WIDTH-parameterised register with async active-low reset, enable and synchronous clear-to-bubble. It is instantiated three times.

Test Plan:
- ADDI then ORI, no hazards (ctrl 0_101_00_00_100, then …101) -> ex_ALUOp=100 at edge 1 and 101 at edge 2; wb_RegWrite=1 at edges 3 and 4; stall and flush stay 0.
- LW rt=8, then R-type ADD rs=8 -> stall=1 for exactly one cycle; EX shows a bubble (ex_ALUOp=000); the ADD reaches EX one cycle late with ex_write_reg=rd.
- LW rt=0, then ADD rs=0 -> stall=0 throughout.
- BEQ with alu_zero=1, followed by ADDI -> flush=1 for one cycle; the ADDI never asserts wb_RegWrite. Repeat with alu_zero=0 -> flush=0 and the ADDI commits.
- LW in EX with a dependent instruction in ID, while BNE is taken in EX -> flush=1, stall=0.
- Assert reset low mid-stream with three instructions in flight -> all outputs read 0 immediately, asynchronously; after release the pipeline refills from ID only.
